// File: rtl/f_fetch_seq_pkg.sv
// Shared definitions for the fetch-stage sequencer.
package f_fetch_seq_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/f_fetch_buf.sv
// One-entry holding register between instruction memory and the IF/ID stage.
// A load wins over a consume, so a simultaneous consume and load keeps the
// entry valid with the new instruction.
module f_fetch_buf
    import f_fetch_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_consume,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // Hold, reload or drain the buffered instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/f_fetch_seq.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests and
// turns D-stage redirects into the correct fetch stream around the delay slot.
//
// state    | meaning
// ST_FETCH | normal fetching; in-flight word is on the correct path
// ST_DROP  | in-flight word at pc_q is wrong-path; wait for its ack, discard
module f_fetch_seq
    import f_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        F_valid,
    output logic [31:0] F_instr,
    output logic [31:0] F_pc
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_redir_pend;
    logic [31:0]  r_redir_q;

    logic w_consume;
    logic w_take;
    logic w_ack;
    logic w_load;
    logic w_fetch;

    assign w_fetch   = (r_state == ST_FETCH);
    assign w_consume = F_valid && !stall;
    // Redirects only matter in FETCH; in DROP the delay slot is already gone.
    assign w_take    = w_fetch && redirect_valid && !stall;

    // Request whenever the buffer can accept the word; DROP always requests
    // so the wrong-path transfer can complete. Reset masks stale acks.
    assign im_req  = reset && (!w_fetch || !(F_valid && stall));
    assign im_addr = r_pc;
    assign w_ack   = im_req && im_ack;

    // A take with a full buffer marks the returning word as wrong-path.
    assign w_load  = w_fetch && w_ack && !(w_take && F_valid);

    // PC, redirect bookkeeping and drop FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_q    <= 32'd0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_take && F_valid) begin
                        r_redir_pend <= 1'b0;
                        if (w_ack) begin
                            r_pc <= redirect_pc;
                        end else begin
                            r_redir_q <= redirect_pc;
                            r_state   <= ST_DROP;
                        end
                    end else if (w_take) begin
                        if (w_ack) begin
                            r_pc         <= redirect_pc;
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_redir_pend <= 1'b1;
                            r_redir_q    <= redirect_pc;
                        end
                    end else if (w_ack) begin
                        r_pc         <= r_redir_pend ? r_redir_q : pc_inc(r_pc);
                        r_redir_pend <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (w_ack) begin
                        r_pc    <= r_redir_q;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    f_fetch_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_consume (w_consume),
        .i_instr   (im_rdata),
        .i_pc      (r_pc),
        .o_valid   (F_valid),
        .o_instr   (F_instr),
        .o_pc      (F_pc)
    );

endmodule

// File: doc/f_fetch_seq.md
# f_fetch_seq

Fetch-stage sequencer that owns the architectural PC register and drives instruction-memory requests. It turns D-stage redirects (taken beq, jal, jr targets computed by the D-stage next-PC logic) into the correct fetch stream while honouring the MIPS branch delay slot. It holds one fetched instruction for the IF/ID register under hazard-unit stalls. It sits between the hazard unit, the D-stage next-PC logic and the instruction memory port.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state.
- stall  in  1  hazard-unit stall. 1 = D does not consume F output this cycle.
- redirect_valid  in  1  D-stage control transfer; sampled only when stall==0.
- redirect_pc  in  32  target address, valid with redirect_valid.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  request address; equals pc_q.
- im_ack  in  1  transfer completes in any cycle with im_req&&im_ack, including the first.
- im_rdata  in  32  instruction word, valid with im_ack.
- F_valid  out  1  F_instr/F_pc hold an instruction for D.
- F_instr  out  32  buffered instruction.
- F_pc  out  32  address of F_instr.

## Operation
- State: pc_q (next fetch address), one-entry output buffer (F_valid/F_instr/F_pc), FSM {FETCH, DROP}, redir_pend, redir_q[31:0].
- consume = F_valid && !stall. take = redirect_valid && !stall.
- FETCH: im_req = !(F_valid && stall). On im_req&&im_ack with no drop condition:
  - F_instr<=im_rdata, F_pc<=pc_q, F_valid<=1.
  - pc_q<=redir_q if redir_pend, else pc_q+4 (mod 2^32). Clear redir_pend.
- If consume and no ack in the same cycle, then F_valid<=0.
- take with F_valid==1: the buffer holds the delay slot, consumed this cycle. The in-flight fetch at pc_q is wrong-path.
  - If im_ack this cycle: discard im_rdata, pc_q<=redirect_pc, F_valid<=0.
  - Otherwise: redir_q<=redirect_pc, go DROP.
- take with F_valid==0: the delay slot is not yet fetched.
  - If im_ack this cycle: capture it normally, pc_q<=redirect_pc.
  - Otherwise: redir_pend<=1, redir_q<=redirect_pc.
- DROP: im_req=1, im_addr=old pc_q, F_valid=0. On im_ack: discard, pc_q<=redir_q, go FETCH. redirect_valid is ignored in DROP.
- Request rule: once im_req rises without ack, im_req and im_addr stay stable until ack. The invariant "unacked request ⇒ F_valid==0 next cycle" guarantees this.
- No alignment checking. redirect_pc is used verbatim.

## Timing
- Reset (reset==0): pc_q=RESET_PC, F_valid=0, F_instr=0, F_pc=0, FSM=FETCH, redir_pend=0, redir_q=0. im_req forced 0 while reset==0.
- First request occurs in the first cycle with reset==1.
- Fetch-to-F latency: F_valid rises at the edge ending the ack cycle. Zero-wait memory gives one instruction per cycle.
- Redirect-to-target request:
  - Same-cycle ack: target is on im_addr the next cycle.
  - DROP: target issues the cycle after the drop ack.
  - Pending case: target issues the cycle after the delay-slot ack.
- Simultaneous consume + ack: the buffer reloads with the new instruction; F_valid stays 1.
- Reset mid-DROP or with redir_pend set: all state is discarded. Any late im_ack after reset is ignored because im_req is 0.
- pc_q wraps 0xFFFF_FFFC+4 to 0x0000_0000.

## Structure
- Shared package: FSM state encoding (FETCH, DROP), default RESET_PC, PC_STEP=4.
- Natural sub-module: f_fetch_buf (one-entry valid/instr/pc holding register with load/consume). The FSM and pc_q stay in f_fetch_seq.

## Test plan
- **Reset, zero-wait memory, stall=0:** im_addr sequence 0x3000, 0x3004, 0x3008. F_pc trails by one cycle. F_valid=1 from the second cycle.
- **stall=1 for 3 cycles with F_valid=1:** im_req=0. F_instr/F_pc are held. Fetching resumes at the next address the cycle stall drops.
- **Redirect to 0x3100 with delay slot 0x3004 buffered, ack of 0x3008 in the same cycle:** 0x3008 data is discarded. The next im_addr is 0x3100. F_valid=0 for one cycle.
- **Same redirect, memory with 2 wait cycles:** DROP holds im_addr=0x3008 until ack, then issues 0x3100. No 0x3008 instruction reaches F.
- **Redirect while F_valid=0, delay slot 0x3004 still pending:** 0x3004 is delivered to F. The next im_addr is 0x3100, not 0x3008.
- **reset=0 asserted during DROP:** next cycle pc_q=0x3000, F_valid=0, im_req=0. After release, fetch restarts at 0x3000.
